// File: rtl/mult_dot_acc_pkg.sv
// Shared constants and width helper for the dot-product accumulator and
// other accumulating stages downstream of the shift-add multiplier.
package mult_dot_acc_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_M = 4;
  localparam int DEF_K = 4;
  localparam int TAG_W = 8;

  // Sum of k unsigned n x m products never exceeds n+m+clog2(k) bits.
  function automatic int acc_width(input int n, input int m, input int k);
    return n + m + $clog2(k);
  endfunction

endpackage

// File: rtl/mult_dot_acc_fifo.sv
// Two-entry synchronous FIFO with a registered head; a push into a full
// FIFO is ignored unless a pop happens in the same cycle.
module mult_dot_acc_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         pop_fire, push_fire;

  assign pop_fire  = pop_i && (cnt_q != 2'd0);
  assign push_fire = push_i && ((cnt_q != 2'd2) || pop_fire);

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push_fire, pop_fire})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = din_i;
        else               tail_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the new entry lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign dout_o  = head_q;
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/mult_dot_acc.sv
// Accumulates K consecutive multiplier products into one sum and buffers
// completed sums in a 2-entry FIFO; MULT_DOT_ACC_TAG_EN adds a sum_tag output.
module mult_dot_acc
  import mult_dot_acc_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int M     = DEF_M,
  parameter int K     = DEF_K,
  parameter int ACC_W = acc_width(N, M, K)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             res_rdy,
  input  logic [N+M-1:0]   res,
  input  logic             clr,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [ACC_W-1:0] sum,
  output logic             busy,
  output logic             ovf
`ifdef MULT_DOT_ACC_TAG_EN
  ,
  output logic [TAG_W-1:0] sum_tag
`endif
);

  localparam int CNT_W = $clog2(K);
`ifdef MULT_DOT_ACC_TAG_EN
  localparam int FW = ACC_W + TAG_W;
`else
  localparam int FW = ACC_W;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             busy_q;
  logic [ACC_W-1:0] res_ext, acc_sum;
  logic             sample, last, pop, full, empty, drop;
  logic [FW-1:0]    fifo_din, fifo_dout;

  assign res_ext = ACC_W'(res);
  assign acc_sum = acc_q + res_ext;
  // clr dominates a coincident sample, so a K-th product under clr never completes.
  assign sample  = res_rdy && !clr;
  assign last    = sample && (cnt_q == CNT_W'(K - 1));
  assign pop     = sum_valid && sum_ready;
  assign drop    = last && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    ovf_d = ovf_q || drop;
    if (clr) begin
      cnt_d = '0;
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (sample) begin
      cnt_d = cnt_q + CNT_W'(1);
      acc_d = (cnt_q == '0) ? res_ext : acc_sum;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      busy_q <= (cnt_d != '0);
    end
  end

`ifdef MULT_DOT_ACC_TAG_EN
  logic [TAG_W-1:0] tag_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             tag_q <= '0;
    else if (last && !drop) tag_q <= tag_q + TAG_W'(1);
  end

  assign fifo_din = {tag_q, acc_sum};
  assign sum_tag  = fifo_dout[FW-1:ACC_W];
`else
  assign fifo_din = acc_sum;
`endif

  mult_dot_acc_fifo #(.W(FW)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (last),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty)
  );

  assign sum_valid = !empty;
  assign sum       = fifo_dout[ACC_W-1:0];
  assign busy      = busy_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mult_dot_acc.sv
// Scoreboard bench for mult_dot_acc: expected sums are queued as products
// are driven and compared when the DUT hands off a sum.
module tb_mult_dot_acc;

  localparam int N     = 4;
  localparam int M     = 4;
  localparam int K     = 4;
  localparam int ACC_W = 10;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             res_rdy = 1'b0;
  logic [N+M-1:0]   res = '0;
  logic             clr = 1'b0;
  logic             sum_ready = 1'b0;
  logic             sum_valid;
  logic [ACC_W-1:0] sum;
  logic             busy;
  logic             ovf;
`ifdef MULT_DOT_ACC_TAG_EN
  logic [7:0]       sum_tag;
  int               tag_q[$];
  int               exp_tag = 0;
`endif

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  int   exp_q[$];
  int   mcnt = 0;
  int   macc = 0;
  logic exp_ovf = 1'b0;

  mult_dot_acc #(.N(N), .M(M), .K(K), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .res_rdy   (res_rdy),
    .res       (res),
    .clr       (clr),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum       (sum),
    .busy      (busy),
    .ovf       (ovf)
`ifdef MULT_DOT_ACC_TAG_EN
    ,
    .sum_tag   (sum_tag)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    res_rdy = 1'b0;
    repeat (n) tick();
  endtask

  // Drives one product pulse and updates the expected-result model.
  task automatic pulse(input int v);
    res_rdy = 1'b1;
    res     = v[N+M-1:0];
    if (clr) begin
      mcnt = 0; macc = 0; exp_ovf = 1'b0;
    end else if (mcnt == K - 1) begin
      if (exp_q.size() == 2 && !sum_ready) begin
        exp_ovf = 1'b1;
      end else begin
        exp_q.push_back(macc + v);
`ifdef MULT_DOT_ACC_TAG_EN
        tag_q.push_back(exp_tag);
        exp_tag = (exp_tag + 1) % 256;
`endif
      end
      mcnt = 0; macc = 0;
    end else begin
      macc += v;
      mcnt++;
    end
    tick();
    res_rdy = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic clear();
    clr = 1'b1;
    mcnt = 0; macc = 0; exp_ovf = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rstn && sum_valid && sum_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", sum_valid, 0);
      end else begin
        check("sum", sum, exp_q.pop_front());
`ifdef MULT_DOT_ACC_TAG_EN
        check("tag", sum_tag, tag_q.pop_front());
`endif
        n_pop++;
      end
    end
  end

  initial begin
    int p0;
    #12;
    check("rst_valid", sum_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    rstn = 1'b1;
    tick();

    // Basic sum: 4 x 225
    sum_ready = 1'b1;
    pulse(225);
    check("basic_busy1", busy, 1);
    pulse(225);
    pulse(225);
    check("basic_busy3", busy, 1);
    pulse(225);
    check("basic_latency", sum_valid, 1);
    check("basic_value", sum, 900);
    check("basic_busy_end", busy, 0);
    tick();
    check("basic_one_beat", sum_valid, 0);
    check("basic_ovf", ovf, exp_ovf);

    // Sparse input
    pulse(1); idle(3);
    check("sparse_busy", busy, 1);
    pulse(2); idle(3);
    pulse(3); idle(3);
    check("sparse_busy3", busy, 1);
    pulse(4);
    check("sparse_busy_end", busy, 0);
    idle(3);

    // Backpressure and drop
    sum_ready = 1'b0;
    repeat (12) pulse(1);
    check("bp_ovf", ovf, exp_ovf);
    check("bp_valid", sum_valid, 1);
    p0 = n_pop;
    sum_ready = 1'b1;
    idle(4);
    check("bp_pops", n_pop - p0, 2);
    check("bp_empty", sum_valid, 0);

    // Full buffer with simultaneous pop and push
    clear();
    check("clr_ovf", ovf, exp_ovf);
    sum_ready = 1'b0;
    repeat (8) pulse(2);
    repeat (3) pulse(5);
    sum_ready = 1'b1;
    pulse(5);
    check("fpp_ovf", ovf, exp_ovf);
    p0 = n_pop;
    idle(4);
    check("fpp_pops", n_pop - p0, 2);
    check("fpp_empty", sum_valid, 0);

    // clr collision with the K-th pulse, ovf set beforehand
    sum_ready = 1'b0;
    repeat (12) pulse(1);
    sum_ready = 1'b1;
    idle(4);
    check("pre_clr_ovf", ovf, exp_ovf);
    repeat (3) pulse(7);
    clr = 1'b1;
    pulse(7);
    check("clr_busy", busy, 0);
    check("clr_valid", sum_valid, 0);
    check("clr_ovf_cleared", ovf, exp_ovf);
    repeat (4) pulse(2);
    check("clr_next_value", sum, 8);
    idle(3);

    // Async reset mid-sum with one sum buffered
    sum_ready = 1'b0;
    repeat (4) pulse(1);
    repeat (2) pulse(3);
    check("pre_rst_valid", sum_valid, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_valid", sum_valid, 0);
    check("arst_sum", sum, 0);
    check("arst_busy", busy, 0);
    check("arst_ovf", ovf, 0);
    exp_q.delete();
    mcnt = 0; macc = 0; exp_ovf = 1'b0;
`ifdef MULT_DOT_ACC_TAG_EN
    tag_q.delete();
    exp_tag = 0;
`endif
    tick();
    rstn = 1'b1;
    sum_ready = 1'b1;
    repeat (4) pulse(3);
    check("post_rst_value", sum, 12);
    idle(4);

    check("drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
